// File: rtl/csa_pkg.sv
// csa_pkg
// Shared definitions for the carry-save accumulator:
//   - csa_state_e : packet FSM states (ACCUM, RESOLVE, OUTPUT)
//   - ops_at_level: vectors still present after a given number of 3:2 levels
//   - tree_levels : number of 3:2 levels needed to reach two vectors
//   - node_base   : offset of a level's vectors in the flattened node array
//   - row_base    : offset of a level's compressor rows in the flattened row list
package csa_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        OUTPUT  = 2'd2
    } csa_state_e;

    // Each level groups vectors in threes: every full group becomes two
    // vectors, and the one or two leftover vectors pass straight through.
    function automatic int ops_at_level(input int n_ops, input int level);
        int n;
        n = n_ops;
        for (int l = 0; l < level; l++) begin
            n = 2 * (n / 3) + (n % 3);
        end
        return n;
    endfunction

    function automatic int tree_levels(input int n_ops);
        int n;
        int levels;
        n      = n_ops;
        levels = 0;
        while (n > 2) begin
            n      = 2 * (n / 3) + (n % 3);
            levels = levels + 1;
        end
        return levels;
    endfunction

    function automatic int node_base(input int n_ops, input int level);
        int base;
        base = 0;
        for (int l = 0; l < level; l++) begin
            base = base + ops_at_level(n_ops, l);
        end
        return base;
    endfunction

    function automatic int row_base(input int n_ops, input int level);
        int base;
        base = 0;
        for (int l = 0; l < level; l++) begin
            base = base + ops_at_level(n_ops, l) / 3;
        end
        return base;
    endfunction

endpackage

// File: rtl/csa_compress_3to2.sv
// csa_compress_3to2
// One row of W independent full adders. Reduces three vectors to a sum
// vector and a carry vector. The carry is returned at its own bit weight
// (unshifted); the parent applies the left shift.
// Ports:
//   a, b, c : input vectors, W bits each
//   sum     : bitwise sum (a ^ b ^ c)
//   carry   : bitwise majority, unshifted
module csa_compress_3to2 #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accumulator.sv
// csa_accumulator
// Streaming multi-operand accumulator. Each accepted beat folds NUM_OPS
// operands into a redundant (acc_s, acc_c) pair through a 3:2 compressor
// tree; the last beat of a packet triggers one carry-propagate add, and the
// resolved total is held on a valid/ready output until taken.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid/in_ready   : input beat handshake
//   in_data             : NUM_OPS unsigned operands, operand i at [i*WIDTH +: WIDTH]
//   in_last             : marks the final beat of a packet
//   out_valid/out_ready : result handshake
//   out_sum             : total modulo 2^ACC_W
//   out_ovf             : true total reached 2^ACC_W or more
//   out_beats           : beats in the packet, saturating
module csa_accumulator
    import csa_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NUM_OPS = 3,
    parameter int GUARD   = 8,
    parameter int CNT_W   = 8,
    localparam int ACC_W  = WIDTH + GUARD
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_OPS*WIDTH-1:0] in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_sum,
    output logic                     out_ovf,
    output logic [CNT_W-1:0]         out_beats
);

    localparam int TOT     = NUM_OPS + 2;
    localparam int LEVELS  = tree_levels(TOT);
    localparam int N_NODES = node_base(TOT, LEVELS + 1);
    localparam int N_ROWS  = row_base(TOT, LEVELS);
    localparam int FINAL_B = node_base(TOT, LEVELS);

    csa_state_e state;
    csa_state_e next_state;

    logic [ACC_W-1:0] acc_s;
    logic [ACC_W-1:0] acc_c;
    logic             ovf_acc;
    logic [CNT_W-1:0] beat_cnt;
    logic             beat_accept;
    logic [ACC_W:0]   cpa;

    // Every vector of every tree level lives in one flat array; level l
    // occupies node[node_base(l) +: ops_at_level(l)].
    logic [ACC_W-1:0] node [N_NODES];
    logic [N_ROWS-1:0] carry_lost;

    assign node[0] = acc_s;
    assign node[1] = acc_c;
    for (genvar i = 0; i < NUM_OPS; i++) begin : g_operand
        assign node[2 + i] = ACC_W'(in_data[i*WIDTH +: WIDTH]);
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_level
        localparam int N_IN  = ops_at_level(TOT, l);
        localparam int N_GRP = N_IN / 3;
        localparam int IN_B  = node_base(TOT, l);
        localparam int OUT_B = node_base(TOT, l + 1);
        localparam int ROW_B = row_base(TOT, l);

        for (genvar g = 0; g < N_GRP; g++) begin : g_row
            logic [ACC_W-1:0] row_carry;

            csa_compress_3to2 #(.W(ACC_W)) u_row (
                .a     (node[IN_B + 3*g]),
                .b     (node[IN_B + 3*g + 1]),
                .c     (node[IN_B + 3*g + 2]),
                .sum   (node[OUT_B + 2*g]),
                .carry (row_carry)
            );

            // The carry MSB has weight 2^ACC_W once shifted; since every
            // term is non-negative, losing it proves the true total overflowed.
            assign node[OUT_B + 2*g + 1] = {row_carry[ACC_W-2:0], 1'b0};
            assign carry_lost[ROW_B + g] = row_carry[ACC_W-1];
        end

        for (genvar r = 0; r < N_IN - 3*N_GRP; r++) begin : g_pass
            assign node[OUT_B + 2*N_GRP + r] = node[IN_B + 3*N_GRP + r];
        end
    end

    assign beat_accept = in_valid && (state == ACCUM);
    assign cpa         = {1'b0, acc_s} + {1'b0, acc_c};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    next_state = RESOLVE;
                end
            end
            RESOLVE: begin
                next_state = OUTPUT;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = ACCUM;
                end
            end
            default: begin
                next_state = ACCUM;
            end
        endcase
    end

    // Accumulator, sticky overflow, beat counter and the registered result.
    // RESOLVE both captures the result and clears the accumulation state so
    // the next packet starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_s     <= '0;
            acc_c     <= '0;
            ovf_acc   <= 1'b0;
            beat_cnt  <= '0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_beats <= '0;
        end else begin
            if (beat_accept) begin
                acc_s   <= node[FINAL_B];
                acc_c   <= node[FINAL_B + 1];
                ovf_acc <= ovf_acc | (|carry_lost);
                if (beat_cnt != '1) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
            if (state == RESOLVE) begin
                out_sum   <= cpa[ACC_W-1:0];
                out_ovf   <= ovf_acc | cpa[ACC_W];
                out_beats <= beat_cnt;
                acc_s     <= '0;
                acc_c     <= '0;
                ovf_acc   <= 1'b0;
                beat_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_csa_accumulator.sv
// tb_csa_accumulator
// Checks csa_accumulator against a packet-level arithmetic model (plain
// 64-bit running totals), with directed literal cases for latency,
// saturation, overflow, backpressure, reset and two other parameter sets.
module tb_csa_accumulator;

    localparam int WIDTH   = 16;
    localparam int NUM_OPS = 3;
    localparam int GUARD   = 8;
    localparam int CNT_W   = 8;
    localparam int ACC_W   = WIDTH + GUARD;

    localparam int PH_ACC = 0;
    localparam int PH_RES = 1;
    localparam int PH_OUT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_OPS*WIDTH-1:0] in_data;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [ACC_W-1:0]         out_sum;
    logic                     out_ovf;
    logic [CNT_W-1:0]         out_beats;

    logic        p5_in_valid, p5_in_ready, p5_in_last, p5_out_valid, p5_out_ready, p5_out_ovf;
    logic [79:0] p5_in_data;
    logic [23:0] p5_out_sum;
    logic [7:0]  p5_out_beats;

    logic        w32_in_valid, w32_in_ready, w32_in_last, w32_out_valid, w32_out_ready, w32_out_ovf;
    logic [95:0] w32_in_data;
    logic [39:0] w32_out_sum;
    logic [7:0]  w32_out_beats;

    int tests_run = 0;
    int tests_failed = 0;

    csa_accumulator #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .GUARD(GUARD), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf), .out_beats(out_beats)
    );

    csa_accumulator #(.WIDTH(16), .NUM_OPS(5), .GUARD(8), .CNT_W(8)) dut_ops5 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(p5_in_valid), .in_ready(p5_in_ready), .in_data(p5_in_data), .in_last(p5_in_last),
        .out_valid(p5_out_valid), .out_ready(p5_out_ready),
        .out_sum(p5_out_sum), .out_ovf(p5_out_ovf), .out_beats(p5_out_beats)
    );

    csa_accumulator #(.WIDTH(32), .NUM_OPS(3), .GUARD(8), .CNT_W(8)) dut_w32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w32_in_valid), .in_ready(w32_in_ready), .in_data(w32_in_data), .in_last(w32_in_last),
        .out_valid(w32_out_valid), .out_ready(w32_out_ready),
        .out_sum(w32_out_sum), .out_ovf(w32_out_ovf), .out_beats(w32_out_beats)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Packet-level reference: a plain integer total and beat count per
    // packet, reduced to the output format only when the packet resolves.
    int                 m_phase;
    longint unsigned    m_total;
    int                 m_beats;
    logic [ACC_W-1:0]   exp_sum;
    logic               exp_ovf;
    logic [CNT_W-1:0]   exp_beats;

    function automatic longint unsigned beatSum(input logic [NUM_OPS*WIDTH-1:0] data);
        longint unsigned s;
        s = 0;
        for (int i = 0; i < NUM_OPS; i++) begin
            s = s + longint'(data[i*WIDTH +: WIDTH]);
        end
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase   <= PH_ACC;
            m_total   <= 0;
            m_beats   <= 0;
            exp_sum   <= '0;
            exp_ovf   <= 1'b0;
            exp_beats <= '0;
        end else begin
            case (m_phase)
                PH_ACC: begin
                    if (in_valid) begin
                        m_total <= m_total + beatSum(in_data);
                        m_beats <= m_beats + 1;
                        if (in_last) m_phase <= PH_RES;
                    end
                end
                PH_RES: begin
                    exp_sum   <= m_total[ACC_W-1:0];
                    exp_ovf   <= (m_total >= (64'd1 << ACC_W));
                    exp_beats <= (m_beats > 255) ? 8'd255 : CNT_W'(m_beats);
                    m_total   <= 0;
                    m_beats   <= 0;
                    m_phase   <= PH_OUT;
                end
                default: begin
                    if (out_ready) m_phase <= PH_ACC;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("cmp_in_ready", in_ready, (m_phase == PH_ACC));
            checkOutput("cmp_out_valid", out_valid, (m_phase == PH_OUT));
            checkOutput("cmp_out_sum", out_sum, exp_sum);
            checkOutput("cmp_out_ovf", out_ovf, exp_ovf);
            checkOutput("cmp_out_beats", out_beats, exp_beats);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NUM_OPS*WIDTH-1:0] data, input logic last);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic waitOutput(input string name);
        for (int i = 0; i < 8 && !out_valid; i++) tick();
        checkOutput(name, out_valid, 1'b1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] rnd;
        in_valid = 0; in_data = '0; in_last = 0; out_ready = 0;
        p5_in_valid = 0; p5_in_data = '0; p5_in_last = 0; p5_out_ready = 1;
        w32_in_valid = 0; w32_in_data = '0; w32_in_last = 0; w32_out_ready = 1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", in_ready, 1'b1);
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_out_sum", out_sum, 24'h0);
        checkOutput("reset_out_beats", out_beats, 8'h0);
        rst_n = 1'b1;
        tick();

        // Single beat, exact two-edge latency
        applyStimulus({16'h5E6F, 16'h3C4D, 16'h1A2B}, 1'b1);
        checkOutput("t1_in_ready_resolve", in_ready, 1'b0);
        checkOutput("t1_out_valid_resolve", out_valid, 1'b0);
        tick();
        checkOutput("t1_out_valid", out_valid, 1'b1);
        checkOutput("t1_out_sum", out_sum, 24'h00B4E7);
        checkOutput("t1_out_ovf", out_ovf, 1'b0);
        checkOutput("t1_out_beats", out_beats, 8'd1);
        handshake();
        checkOutput("t1_out_valid_after", out_valid, 1'b0);
        checkOutput("t1_in_ready_after", in_ready, 1'b1);

        // Carry into the guard bits; in_ready low until the handshake
        applyStimulus({16'h0001, 16'h0001, 16'hFFFF}, 1'b1);
        checkOutput("t2_in_ready_resolve", in_ready, 1'b0);
        tick();
        checkOutput("t2_in_ready_output", in_ready, 1'b0);
        checkOutput("t2_out_sum", out_sum, 24'h010001);
        checkOutput("t2_out_ovf", out_ovf, 1'b0);
        handshake();
        checkOutput("t2_in_ready_after", in_ready, 1'b1);

        // 256 full-scale beats: overflow and counter saturation
        for (int i = 0; i < 256; i++) begin
            applyStimulus({16'hFFFF, 16'hFFFF, 16'hFFFF}, (i == 255));
        end
        waitOutput("t3_out_valid");
        checkOutput("t3_out_sum", out_sum, 24'hFFFD00);
        checkOutput("t3_out_ovf", out_ovf, 1'b1);
        checkOutput("t3_out_beats", out_beats, 8'hFF);
        handshake();

        // Backpressure holds the result stable
        applyStimulus({16'h3333, 16'h2222, 16'h1111}, 1'b1);
        waitOutput("t4_out_valid");
        for (int i = 0; i < 5; i++) begin
            checkOutput("t4_hold_valid", out_valid, 1'b1);
            checkOutput("t4_hold_sum", out_sum, 24'h006666);
            tick();
        end
        handshake();
        checkOutput("t4_out_valid_after", out_valid, 1'b0);
        checkOutput("t4_in_ready_after", in_ready, 1'b1);

        // Reset mid-packet discards the partial accumulation
        applyStimulus({16'h0100, 16'h0100, 16'h0100}, 1'b0);
        applyStimulus({16'h0100, 16'h0100, 16'h0100}, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_out_sum", out_sum, 24'h0);
        checkOutput("t5_rst_out_valid", out_valid, 1'b0);
        checkOutput("t5_rst_out_ovf", out_ovf, 1'b0);
        checkOutput("t5_rst_out_beats", out_beats, 8'h0);
        checkOutput("t5_rst_in_ready", in_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus({16'h0003, 16'h0002, 16'h0001}, 1'b1);
        waitOutput("t5_out_valid");
        checkOutput("t5_out_sum", out_sum, 24'h000006);
        checkOutput("t5_out_beats", out_beats, 8'd1);

        // Reset while a result is waiting drops it
        rst_n = 1'b0;
        #1;
        checkOutput("t5b_rst_out_valid", out_valid, 1'b0);
        checkOutput("t5b_rst_out_sum", out_sum, 24'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Other parameter sets
        p5_in_data   = {16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        p5_in_valid  = 1'b1; p5_in_last = 1'b1;
        w32_in_data  = {32'h1, 32'h1, 32'hFFFF_FFFF};
        w32_in_valid = 1'b1; w32_in_last = 1'b1;
        tick();
        p5_in_valid = 1'b0; p5_in_last = 1'b0;
        w32_in_valid = 1'b0; w32_in_last = 1'b0;
        tick();
        checkOutput("t6_ops5_valid", p5_out_valid, 1'b1);
        checkOutput("t6_ops5_sum", p5_out_sum, 24'h00000F);
        checkOutput("t6_w32_valid", w32_out_valid, 1'b1);
        checkOutput("t6_w32_sum", w32_out_sum, 40'h01_0000_0001);
        checkOutput("t6_w32_ovf", w32_out_ovf, 1'b0);
        tick();
        checkOutput("t6_ops5_valid_after", p5_out_valid, 1'b0);
        checkOutput("t6_ops5_in_ready_after", p5_in_ready, 1'b1);
        checkOutput("t6_w32_in_ready_after", w32_in_ready, 1'b1);

        // Random traffic, including beats offered while the block is busy
        for (int i = 0; i < 3000; i++) begin
            rnd       = {$urandom, $urandom};
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = rnd[NUM_OPS*WIDTH-1:0];
            in_last   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 1) == 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
